// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the keyboard
// clock, then shifts in 11-bit frames with parity, stop and timeout checks.
module ps2_rx #(
  parameter int unsigned FILT    = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       CK,
  input  logic       RS,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       PERR,
  output logic       FERR
);

  localparam int unsigned FW = $clog2(FILT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic          ck_s1_q, ck_s2_q;
  logic          dt_s1_q, dt_s2_q;
  logic          fclk_q, fclk_d;
  logic          fclk_d1_q;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          strobe;

  state_t        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          expired;

  // Bus idles high, so synchronizers reset to 1.
  always_ff @(posedge CK or posedge RS) begin
    if (RS) begin
      ck_s1_q <= 1'b1;
      ck_s2_q <= 1'b1;
      dt_s1_q <= 1'b1;
      dt_s2_q <= 1'b1;
    end else begin
      ck_s1_q <= PS2_CLK;
      ck_s2_q <= ck_s1_q;
      dt_s1_q <= PS2_DAT;
      dt_s2_q <= dt_s1_q;
    end
  end

  always_comb begin
    fclk_d = fclk_q;
    fcnt_d = '0;
    if (ck_s2_q != fclk_q) begin
      if (fcnt_q == FW'(FILT - 1)) begin
        fclk_d = ck_s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CK or posedge RS) begin
    if (RS) begin
      fclk_q    <= 1'b1;
      fclk_d1_q <= 1'b1;
      fcnt_q    <= '0;
    end else begin
      fclk_q    <= fclk_d;
      fclk_d1_q <= fclk_q;
      fcnt_q    <= fcnt_d;
    end
  end

  assign strobe  = fclk_d1_q & ~fclk_q;
  assign expired = (state_q != S_IDLE) && (tmo_q == TW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    tmo_d   = tmo_q + 1'b1;
    if (state_q == S_IDLE || strobe) begin
      tmo_d = '0;
    end
    // A strobe coinciding with expiry wins.
    if (strobe) begin
      unique case (state_q)
        S_IDLE: begin
          if (!dt_s2_q) begin
            state_d = S_DATA;
            bcnt_d  = 3'd0;
          end
        end
        S_DATA: begin
          shift_d = {dt_s2_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          par_d   = dt_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!dt_s2_q) begin
            ferr_d = 1'b1;
          end else if (^{shift_q, par_q}) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (expired) begin
      state_d = S_IDLE;
      shift_d = '0;
      ferr_d  = 1'b1;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge CK or posedge RS) begin
    if (RS) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign DATA  = data_q;
  assign VALID = valid_q;
  assign PERR  = perr_q;
  assign FERR  = ferr_q;

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 The block SHALL have parameter FILT, default 8, giving the consecutive equal samples needed to accept a PS2_CLK level change.
REQ-002 The block SHALL have parameter TIMEOUT, default 50000, giving the CK cycles (1 ms at 50 MHz) allowed between falling edges inside a frame.
REQ-003 The block SHALL have one clock and asynchronous active-high reset: CK  in  1  50 MHz system clock, rising edge.
REQ-004 The block SHALL have RS  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have PS2_CLK  in  1  keyboard clock, asynchronous to CK.
REQ-006 The block SHALL have PS2_DAT  in  1  keyboard data, asynchronous to CK.
REQ-007 The block SHALL have DATA  out  8  last good scan-code byte, held until the next good frame.
REQ-008 The block SHALL have VALID  out  1  one-cycle pulse when DATA updates.
REQ-009 The block SHALL have PERR  out  1  one-cycle pulse on parity error.
REQ-010 The block SHALL have FERR  out  1  one-cycle pulse on bad stop bit or timeout.

Function
REQ-011 PS2_CLK and PS2_DAT SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Filtered clock SHALL change level only after FILT consecutive CK samples of the new synchronized level; shorter pulses are ignored.
REQ-013 A falling edge of filtered clock SHALL be a one-cycle internal strobe; PS2_DAT (synchronized) is sampled in that cycle.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY, STOP; the reset state is IDLE.
REQ-015 IDLE: strobe with data 0 (start bit) -> DATA with bit count 0; strobe with data 1 -> stay IDLE, no output pulse.
REQ-016 DATA: each strobe shifts the sampled bit in LSB-first; after the 8th bit -> PARITY.
REQ-017 PARITY: strobe records the parity bit -> STOP.
REQ-018 STOP: strobe with data 1 and odd parity over 8 data bits plus parity bit -> DATA loaded, VALID pulse, IDLE.
REQ-019 STOP: strobe with data 1 and even parity -> PERR pulse, DATA unchanged, IDLE.
REQ-020 STOP: strobe with data 0 -> FERR pulse, DATA unchanged, IDLE; FERR takes priority over PERR.
REQ-021 VALID, PERR and FERR SHALL assert in the CK cycle after the stop-bit strobe, for exactly one cycle, and are mutually exclusive.
REQ-022 The timeout counter SHALL clear on every strobe and in IDLE, and increment every cycle in any other state.
REQ-023 When the timeout counter reaches TIMEOUT outside IDLE -> FERR pulse next cycle, shift register discarded, IDLE.
REQ-024 The counter SHALL be wide enough for TIMEOUT without wrap; the bit count SHALL be 3 bits, wrapping only on DATA exit.
REQ-025 A strobe in the same cycle as timeout expiry SHALL take priority: strobe processed, no FERR.

Reset
REQ-026 RS high SHALL force, asynchronously, IDLE, DATA=8'h00, VALID=PERR=FERR=0, counters cleared, synchronizers and filtered clock set to 1 (bus idle).
REQ-027 RS asserted mid-frame SHALL discard the partial frame; after release the first recognized start bit begins a new frame.
REQ-028 No output pulse SHALL be generated on or because of reset release.

Verification
REQ-029 Frame start 0, data 0x1C LSB-first (0,0,1,1,1,0,0,0), parity 0, stop 1, bit period 50 us -> one VALID pulse, DATA=8'h1C, PERR=FERR=0.
REQ-030 Same frame with parity 1 -> one PERR pulse, no VALID, DATA keeps its previous value.
REQ-031 Frame of 0x1C with stop 0 -> one FERR pulse; next frame 0xF0, parity 1, stop 1 -> VALID, DATA=8'hF0.
REQ-032 Start plus 4 data bits then PS2_CLK held high -> FERR pulse TIMEOUT+1 cycles after the last strobe, state IDLE; following good 0x1C frame -> VALID.
REQ-033 3-cycle low glitch on PS2_CLK in IDLE with PS2_DAT=0 (FILT=8) -> no frame start; a following good 0x1C frame is received normally.
REQ-034 RS pulsed after the 5th data bit of a frame -> outputs at reset values, no pulse; next good 0x5A frame (parity 1) -> VALID, DATA=8'h5A.
